// File: rtl/mem_io_bus_arbiter_if.sv
// Bus bundle for mem_io_bus_arbiter: two requester handshakes plus the shared
// data-memory / MMIO side. The arbiter connects through the slave modport,
// and the environment (requesters, memory, IO devices) through the master modport.
interface mem_io_bus_arbiter_if;
    // requester 0 (CPU load/store port)
    logic        m0_req;
    logic        m0_we;
    logic [31:0] m0_addr;
    logic [31:0] m0_wdata;
    logic        m0_gnt;
    logic        m0_done;
    logic [31:0] m0_rdata;
    // requester 1 (UART program/debug loader)
    logic        m1_req;
    logic        m1_we;
    logic [31:0] m1_addr;
    logic [31:0] m1_wdata;
    logic        m1_gnt;
    logic        m1_done;
    logic [31:0] m1_rdata;
    // shared memory / IO side
    logic        mem_en;
    logic        mem_we;
    logic        io_rd;
    logic        io_wr;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] mem_rdata;
    logic [15:0] io_rdata;
    logic        busy;

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        input  m0_gnt, m0_done, m0_rdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        input  m1_gnt, m1_done, m1_rdata,
        input  mem_en, mem_we, io_rd, io_wr, bus_addr, bus_wdata, busy,
        output mem_rdata, io_rdata
    );

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        output m0_gnt, m0_done, m0_rdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        output m1_gnt, m1_done, m1_rdata,
        output mem_en, mem_we, io_rd, io_wr, bus_addr, bus_wdata, busy,
        input  mem_rdata, io_rdata
    );
endinterface

// File: rtl/mem_io_bus_arbiter.sv
// mem_io_bus_arbiter: round-robin sharing of the data-memory / MMIO bus
// between the CPU load/store port (m0) and the UART loader (m1).
// One transaction at a time: IDLE -> ACCESS -> (WAIT) -> DONE -> IDLE.
// All outputs are registered; the next-cycle values are computed from the
// next state so nothing combinational reaches an output from a request.
// Optional build macro IO_WAIT_STATE_EN: IO accesses hold ACCESS for
// 1+IO_WAIT cycles with the IO strobe asserted throughout.
module mem_io_bus_arbiter #(
    parameter int unsigned MEM_LAT = 1,
    parameter logic [21:0] IO_BASE = 22'h3FFFFF,
    parameter int unsigned IO_WAIT = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_io_bus_arbiter_if.slave  bus
);

    localparam int CW = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic [CW-1:0]   cnt_r;
    logic            last_grant_r;
    logic            owner_r;
    logic            we_r;
    logic            is_io_r;
    logic [31:0]     addr_r;
    logic [31:0]     wdata_r;

    logic            start_s;
    logic            sel_owner_s;
    logic            hold_s;
    logic [31:0]     rdata_nxt_s;
    logic            sel_we_s;
    logic [31:0]     sel_addr_s;
    logic [31:0]     sel_wdata_s;
    logic            nxt_is_io_s;
    logic            nxt_we_s;
    logic            acc_nxt_s;
    logic            done_nxt_s;

    logic            m0_gnt_r;
    logic            m1_gnt_r;
    logic            m0_done_r;
    logic            m1_done_r;
    logic [31:0]     m0_rdata_r;
    logic [31:0]     m1_rdata_r;
    logic            mem_en_r;
    logic            mem_we_r;
    logic            io_rd_r;
    logic            io_wr_r;
    logic            busy_r;

    // Next-state logic: arbitration in IDLE, strobe phase length, read-data selection.
    always_comb begin
        state_nxt_s = state_r;
        start_s     = 1'b0;
        sel_owner_s = 1'b0;
        hold_s      = 1'b0;
        rdata_nxt_s = 32'h0000_0000;
        case (state_r)
            IDLE: begin
                if (bus.m0_req && bus.m1_req) begin
                    start_s     = 1'b1;
                    sel_owner_s = ~last_grant_r;
                end else if (bus.m0_req) begin
                    start_s     = 1'b1;
                    sel_owner_s = 1'b0;
                end else if (bus.m1_req) begin
                    start_s     = 1'b1;
                    sel_owner_s = 1'b1;
                end else begin
                    start_s     = 1'b0;
                    sel_owner_s = 1'b0;
                end
                if (start_s) begin
                    state_nxt_s = ACCESS;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ACCESS: begin
`ifdef IO_WAIT_STATE_EN
                if (is_io_r && (cnt_r < CW'(IO_WAIT))) begin
                    hold_s = 1'b1;
                end else begin
                    hold_s = 1'b0;
                end
`else
                hold_s = 1'b0;
`endif
                if (hold_s) begin
                    state_nxt_s = ACCESS;
                end else if (!we_r && !is_io_r) begin
                    state_nxt_s = WAIT;
                end else begin
                    state_nxt_s = DONE;
                    // IO read data is sampled while io_rd is still asserted; writes return 0.
                    if (is_io_r && !we_r) begin
                        rdata_nxt_s = {16'h0000, bus.io_rdata};
                    end else begin
                        rdata_nxt_s = 32'h0000_0000;
                    end
                end
            end
            WAIT: begin
                if (cnt_r == CW'(MEM_LAT - 32'd1)) begin
                    state_nxt_s = DONE;
                    rdata_nxt_s = bus.mem_rdata;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            DONE: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Candidate request fields and the attributes the next cycle will see.
    always_comb begin
        if (sel_owner_s) begin
            sel_we_s    = bus.m1_we;
            sel_addr_s  = bus.m1_addr;
            sel_wdata_s = bus.m1_wdata;
        end else begin
            sel_we_s    = bus.m0_we;
            sel_addr_s  = bus.m0_addr;
            sel_wdata_s = bus.m0_wdata;
        end
        if (start_s) begin
            nxt_is_io_s = (sel_addr_s[31:10] == IO_BASE);
            nxt_we_s    = sel_we_s;
        end else begin
            nxt_is_io_s = is_io_r;
            nxt_we_s    = we_r;
        end
        acc_nxt_s  = (state_nxt_s == ACCESS);
        done_nxt_s = (state_nxt_s == DONE);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Phase counter: restarts on every state change, counts cycles spent in ACCESS/WAIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {CW{1'b0}};
        end else if ((state_nxt_s != state_r) || (state_r == IDLE)) begin
            cnt_r <= {CW{1'b0}};
        end else begin
            cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end
    end

    // Transaction latches, captured at grant and held until the next grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_r <= 1'b0;
            we_r    <= 1'b0;
            is_io_r <= 1'b0;
            addr_r  <= 32'h0000_0000;
            wdata_r <= 32'h0000_0000;
        end else if (start_s) begin
            owner_r <= sel_owner_s;
            we_r    <= sel_we_s;
            is_io_r <= nxt_is_io_s;
            addr_r  <= sel_addr_s;
            wdata_r <= sel_wdata_s;
        end else begin
            owner_r <= owner_r;
            we_r    <= we_r;
            is_io_r <= is_io_r;
            addr_r  <= addr_r;
            wdata_r <= wdata_r;
        end
    end

    // Round-robin memory: the owner of a finished transaction loses the next tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_r <= 1'b1;
        end else if (state_r == DONE) begin
            last_grant_r <= owner_r;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end

    // Registered outputs, loaded with the values belonging to the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m0_gnt_r   <= 1'b0;
            m1_gnt_r   <= 1'b0;
            m0_done_r  <= 1'b0;
            m1_done_r  <= 1'b0;
            m0_rdata_r <= 32'h0000_0000;
            m1_rdata_r <= 32'h0000_0000;
            mem_en_r   <= 1'b0;
            mem_we_r   <= 1'b0;
            io_rd_r    <= 1'b0;
            io_wr_r    <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            m0_gnt_r   <= start_s && !sel_owner_s;
            m1_gnt_r   <= start_s && sel_owner_s;
            m0_done_r  <= done_nxt_s && !owner_r;
            m1_done_r  <= done_nxt_s && owner_r;
            m0_rdata_r <= (done_nxt_s && !owner_r) ? rdata_nxt_s : 32'h0000_0000;
            m1_rdata_r <= (done_nxt_s && owner_r)  ? rdata_nxt_s : 32'h0000_0000;
            mem_en_r   <= acc_nxt_s && !nxt_is_io_s;
            mem_we_r   <= acc_nxt_s && !nxt_is_io_s && nxt_we_s;
            io_rd_r    <= acc_nxt_s && nxt_is_io_s && !nxt_we_s;
            io_wr_r    <= acc_nxt_s && nxt_is_io_s && nxt_we_s;
            busy_r     <= (state_nxt_s != IDLE);
        end
    end

    assign bus.m0_gnt    = m0_gnt_r;
    assign bus.m1_gnt    = m1_gnt_r;
    assign bus.m0_done   = m0_done_r;
    assign bus.m1_done   = m1_done_r;
    assign bus.m0_rdata  = m0_rdata_r;
    assign bus.m1_rdata  = m1_rdata_r;
    assign bus.mem_en    = mem_en_r;
    assign bus.mem_we    = mem_we_r;
    assign bus.io_rd     = io_rd_r;
    assign bus.io_wr     = io_wr_r;
    assign bus.bus_addr  = addr_r;
    assign bus.bus_wdata = wdata_r;
    assign bus.busy      = busy_r;

endmodule

// File: doc/mem_io_bus_arbiter.md
Name: mem_io_bus_arbiter

Overview:
- Sequences and shares the data-memory / MMIO bus that sits behind the MemOrIO path between two requesters.
- Requester 0 is the CPU load/store port; requester 1 is the UART program/debug loader.
- Per transaction: round-robin arbitration, address decode (memory vs IO space), strobe generation, memory read-latency wait, and registered return of read data with a one-cycle done pulse.

Parameters:
- MEM_LAT, 1, synchronous data-memory read latency in cycles (>=1).
- IO_BASE, 22'h3FFFFF, addr[31:10] value that selects IO space (0xFFFFFC00-0xFFFFFFFF).
- IO_WAIT, 2, extra IO wait cycles; used only when IO_WAIT_STATE_EN is defined.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- m0_req  in  1  requester 0 transaction request.
- m0_we  in  1  1 = write, 0 = read.
- m0_addr  in  32  byte address.
- m0_wdata  in  32  write data.
- m0_gnt  out  1  one-cycle pulse: request accepted.
- m0_done  out  1  one-cycle pulse: transaction complete.
- m0_rdata  out  32  read data, valid while m0_done is high.
- m1_req / m1_we / m1_addr / m1_wdata / m1_gnt / m1_done / m1_rdata: same as m0_*, for requester 1.
- mem_en  out  1  data-memory access strobe.
- mem_we  out  1  data-memory write enable.
- io_rd  out  1  IO read strobe.
- io_wr  out  1  IO write strobe.
- bus_addr  out  32  latched address.
- bus_wdata  out  32  latched write data.
- mem_rdata  in  32  data-memory read data.
- io_rdata  in  16  IO read data, combinational from the device.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Clocking and reset
  - Single clock domain.
  - rst is asynchronous, active-high.
  - Reset forces state=IDLE, last_grant=1 (m0 wins the first tie), and all outputs, latches and counters to 0.
- States
  - IDLE, ACCESS, WAIT, DONE.
  - All outputs are registered or decoded from state only; there is no combinational req->output path.
- IDLE
  - Samples requests every cycle.
  - If exactly one req is high, grant it.
  - If both are high, grant the requester != last_grant.
  - On grant: latch owner, we, addr, wdata; compute is_io = (addr[31:10]==IO_BASE); move to ACCESS.
- ACCESS (exactly 1 cycle)
  - gnt of the owner is high.
  - Exactly one strobe is high:
    - memory read: mem_en
    - memory write: mem_en & mem_we
    - IO read: io_rd
    - IO write: io_wr
  - bus_addr and bus_wdata hold the latched values from ACCESS through DONE.
  - Next state:
    - memory read -> WAIT
    - any write or IO read -> DONE
  - IO read captures {16'h0000, io_rdata} into the rdata register at the end of ACCESS.
- WAIT
  - Counter runs for MEM_LAT cycles; strobes are low.
  - mem_rdata is captured at the end of the last WAIT cycle; then move to DONE.
- DONE (1 cycle)
  - Owner's done is high and its rdata is valid. Writes return rdata=0.
  - last_grant <= owner; move to IDLE.
  - The non-owner's done and rdata stay 0.
- Latency, with req high in cycle 0:
  - gnt in cycle 1.
  - Memory read: done in cycle 2+MEM_LAT.
  - Write or IO read: done in cycle 2.
- Handshake
  - req is sampled only in IDLE. Dropping req mid-transaction does not abort the transaction.
  - A req still high in the IDLE cycle after DONE is treated as a new transaction.
  - Round-robin bounds the wait of a continuously requesting master to one transaction.
- IO writes drive the full 32-bit bus_wdata; devices use [15:0].
- Reset mid-transaction: aborted immediately. No done pulse is issued and the requester must reissue.

Optional Feature:
- Macro: IO_WAIT_STATE_EN.
- Defined: IO accesses stay in ACCESS for 1+IO_WAIT cycles. io_rd/io_wr are held for the whole period, and io_rdata is captured on the final cycle. gnt still pulses only on the first ACCESS cycle.
- Undefined: IO strobes last exactly 1 cycle and the IO_WAIT parameter is ignored.

Test Plan:
- Read: m0 reads 0x00000010 with mem_rdata=0xDEADBEEF, MEM_LAT=1 -> m0_gnt and mem_en in cycle 1; m0_done in cycle 3 with m0_rdata=0xDEADBEEF; io_rd/io_wr stay 0.
- IO read: m1 reads 0xFFFFFC70 with io_rdata=16'hA5A5 -> io_rd in cycle 1; m1_done in cycle 2 with m1_rdata=0x0000A5A5; mem_en stays 0.
- IO write: m0 writes 0xFFFFFC60 with wdata=0x123400FF -> io_wr for 1 cycle with bus_wdata=0x123400FF and bus_addr=0xFFFFFC60; m0_done in cycle 2; mem_we stays 0.
- Arbitration: after reset, m0_req and m1_req held high together -> grant order m0, m1, m0, m1; each done goes only to its own owner.
- Reset abort: rst pulses during WAIT of an m0 read -> all outputs 0 immediately with no m0_done; after release, with both reqs high, m0 is granted first.
- Wait states: with IO_WAIT_STATE_EN defined and IO_WAIT=2, m0 reads 0xFFFFFC70 -> io_rd high in cycles 1-3; m0_done in cycle 4.
